// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: NOP encoding, PC step,
// FSM state encoding and the fetch-queue entry layout.
package if_pkg;

    localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
    localparam logic [31:0] PC_INCREMENT = 32'd4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DRAIN = 2'd2,
        FAULT = 2'd3
    } if_state_e;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/instruction_fetch_unit_fetch_queue.sv
// fetch_queue: two-entry FIFO of fetched {instr, pc} pairs.
// Flush wins over a push in the same cycle; push and pop may coincide at any
// fill level (the caller only pushes into a full queue when it also pops).
module fetch_queue
    import if_pkg::*;
(
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         push_i,
    input  fetch_entry_t push_entry_i,
    input  logic         pop_i,
    input  logic         flush_i,
    output logic [1:0]   count_o,
    output fetch_entry_t head_o
);

    fetch_entry_t mem_q [2];
    logic         rd_ptr_q, rd_ptr_d;
    logic         wr_ptr_q, wr_ptr_d;
    logic [1:0]   count_q, count_d;
    logic         do_pop;

    // Next pointer/count values; flush empties the queue outright.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        do_pop   = pop_i && (count_q != 2'd0);
        if (flush_i) begin
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (push_i) begin
                wr_ptr_d = ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            count_d = count_q + {1'b0, push_i} - {1'b0, do_pop};
        end
    end

    // Control state register with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; data needs no reset because count gates visibility.
    always_ff @(posedge clk_i) begin
        if (push_i && !flush_i) begin
            mem_q[wr_ptr_q] <= push_entry_i;
        end
    end

    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: IF stage of the RV32 pipeline. Generates the fetch
// PC, runs the instruction-memory read handshake, buffers words in a 2-entry
// queue and handles EX redirects (draining an in-flight read if needed).
// Optional macro IF_MISALIGN_TRAP_EN adds FETCH_MISALIGNED and a FAULT state
// entered on misaligned redirect targets; without it the target's low two
// bits are ignored.
module instruction_fetch_unit
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          QUEUE_DEPTH = 2
)
(
    input  logic        CLK,
    input  logic        RESET_N,
    output logic [31:0] IMEM_ADDR,
    output logic        IMEM_READ,
    input  logic [31:0] IMEM_READDATA,
    input  logic        IMEM_BUSYWAIT,
    input  logic        BRANCH_TAKEN,
    input  logic [31:0] BRANCH_TARGET,
    input  logic        STALL,
    output logic [31:0] INSTRUCTION,
    output logic [31:0] PC,
    output logic        VALID
`ifdef IF_MISALIGN_TRAP_EN
    ,
    output logic        FETCH_MISALIGNED
`endif
);

    localparam logic [1:0] FULL_COUNT = 2'(QUEUE_DEPTH);

    if_state_e    state_q, state_d;
    logic [31:0]  fetch_pc_q, fetch_pc_d;
    logic [31:0]  drain_addr_q, drain_addr_d;
    logic [31:0]  pc_last_q;
    logic [31:0]  target;
    logic         read, push, pop, flush, valid;
    logic [1:0]   count;
    fetch_entry_t head, push_entry;
`ifdef IF_MISALIGN_TRAP_EN
    logic         target_mis;
    logic         mis_q, mis_d;

    assign target     = BRANCH_TARGET;
    assign target_mis = |(BRANCH_TARGET & 32'd3);
`else
    assign target     = BRANCH_TARGET & ~32'd3;
`endif

    assign valid      = (count != 2'd0);
    assign pop        = valid && !STALL;
    assign push_entry = '{instr: IMEM_READDATA, pc: fetch_pc_q};

    fetch_queue u_queue (
        .clk_i        (CLK),
        .rst_ni       (RESET_N),
        .push_i       (push),
        .push_entry_i (push_entry),
        .pop_i        (pop),
        .flush_i      (flush),
        .count_o      (count),
        .head_o       (head)
    );

    // Fetch FSM: request issue, completion push, redirect/drain handling.
    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        drain_addr_d = drain_addr_q;
        read         = 1'b0;
        push         = 1'b0;
        flush        = 1'b0;
`ifdef IF_MISALIGN_TRAP_EN
        mis_d        = mis_q;
`endif
        case (state_q)
            IDLE: begin
                state_d = REQ;
            end
            REQ: begin
                // A full queue may only take a new word if ID drains one now.
                read = (count != FULL_COUNT) || pop;
                if (read && !IMEM_BUSYWAIT) begin
                    push       = 1'b1;
                    fetch_pc_d = fetch_pc_q + PC_INCREMENT;
                end
            end
            DRAIN: begin
                // Hold the abandoned request until memory finishes it; data is dropped.
                read = 1'b1;
                if (!IMEM_BUSYWAIT) begin
`ifdef IF_MISALIGN_TRAP_EN
                    state_d = mis_q ? FAULT : REQ;
`else
                    state_d = REQ;
`endif
                end
            end
`ifdef IF_MISALIGN_TRAP_EN
            FAULT: begin
                read = 1'b0;
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase

        // Redirect overrides everything above, including STALL.
        if (BRANCH_TAKEN) begin
            flush      = 1'b1;
            push       = 1'b0;
            fetch_pc_d = target;
            if (state_q == REQ && read && IMEM_BUSYWAIT) begin
                state_d      = DRAIN;
                drain_addr_d = fetch_pc_q;
            end else if (state_q == DRAIN && IMEM_BUSYWAIT) begin
                state_d = DRAIN;
            end else begin
                state_d = REQ;
            end
`ifdef IF_MISALIGN_TRAP_EN
            mis_d = target_mis;
            if (target_mis && state_d == REQ) begin
                state_d = FAULT;
            end
`endif
        end
    end

    // FSM, fetch PC and last-shown PC registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            pc_last_q  <= 32'd0;
`ifdef IF_MISALIGN_TRAP_EN
            mis_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            if (valid) begin
                pc_last_q <= head.pc;
            end
`ifdef IF_MISALIGN_TRAP_EN
            mis_q      <= mis_d;
`endif
        end
    end

    // Address of the abandoned read, replayed on the bus while draining.
    always_ff @(posedge CLK) begin
        drain_addr_q <= drain_addr_d;
    end

    assign IMEM_READ   = read;
    assign IMEM_ADDR   = ((state_q == DRAIN) ? drain_addr_q : fetch_pc_q) & ~32'd3;
    assign VALID       = valid;
    assign INSTRUCTION = valid ? head.instr : NOP_INSTR;
    assign PC          = valid ? head.pc : pc_last_q;
`ifdef IF_MISALIGN_TRAP_EN
    assign FETCH_MISALIGNED = mis_q;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit. The memory returns
// addr ^ 32'hA5A5_0000 with a configurable number of busy cycles per access.
// The model is the ideal instruction stream: consecutive word PCs from the
// last reset/redirect target; every instruction ID consumes must be the next
// element of that stream.
module tb_instruction_fetch_unit;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic [31:0] IMEM_ADDR;
    logic        IMEM_READ;
    logic [31:0] IMEM_READDATA;
    logic        IMEM_BUSYWAIT;
    logic        BRANCH_TAKEN;
    logic [31:0] BRANCH_TARGET;
    logic        STALL;
    logic [31:0] INSTRUCTION;
    logic [31:0] PC;
    logic        VALID;
`ifdef IF_MISALIGN_TRAP_EN
    logic        FETCH_MISALIGNED;
`endif

    always #5 CLK = ~CLK;

    instruction_fetch_unit #(.RESET_PC(32'h0000_0000), .QUEUE_DEPTH(2)) dut (
        .CLK           (CLK),
        .RESET_N       (RESET_N),
        .IMEM_ADDR     (IMEM_ADDR),
        .IMEM_READ     (IMEM_READ),
        .IMEM_READDATA (IMEM_READDATA),
        .IMEM_BUSYWAIT (IMEM_BUSYWAIT),
        .BRANCH_TAKEN  (BRANCH_TAKEN),
        .BRANCH_TARGET (BRANCH_TARGET),
        .STALL         (STALL),
        .INSTRUCTION   (INSTRUCTION),
        .PC            (PC),
        .VALID         (VALID)
`ifdef IF_MISALIGN_TRAP_EN
        ,
        .FETCH_MISALIGNED (FETCH_MISALIGNED)
`endif
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t        exp_q[$];
    int          errors = 0;
    int          checks = 0;
    int          pop_cnt = 0;
    int          wait_left = 0;
    int          wait_min = 0;
    int          wait_max = 0;
    logic [31:0] next_pc = 32'd0;
    logic        model_fault = 1'b0;
    logic        pend_br = 1'b0;
    logic [31:0] pend_tgt = 32'd0;

    assign IMEM_READDATA = IMEM_ADDR ^ 32'hA5A5_0000;
    assign IMEM_BUSYWAIT = (wait_left != 0);

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    // Memory: counts busy cycles per access and checks bus stability.
    initial begin : memory
        logic        rd, busy, pend;
        logic [31:0] paddr;
        pend  = 1'b0;
        paddr = 32'd0;
        forever begin
            @(negedge CLK); #3;
            if (pend) begin
                check32("read_hold", 32'(IMEM_READ), 32'd1);
                check32("addr_hold", IMEM_ADDR, paddr);
            end
            if (IMEM_READ === 1'b1) check32("addr_align", 32'(IMEM_ADDR[1:0]), 32'd0);
            rd    = (IMEM_READ === 1'b1);
            busy  = IMEM_BUSYWAIT;
            pend  = rd && busy && (RESET_N === 1'b1);
            paddr = IMEM_ADDR;
            @(posedge CLK); #1;
            if (rd) begin
                if (wait_left != 0) wait_left--;
                else wait_left = int'($urandom_range(wait_max, wait_min));
            end
        end
    end

    // Monitor: every consumed instruction must be the next stream element.
    initial begin : monitor
        logic prev_br;
        exp_t e;
        prev_br = 1'b0;
        forever begin
            @(negedge CLK); #3;
            if (prev_br) check32("valid_after_redirect", 32'(VALID), 32'd0);
            if (RESET_N === 1'b1 && VALID === 1'b1 && STALL === 1'b0) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_instr: got pc %h, required no instruction", PC);
                end else begin
                    e = exp_q.pop_front();
                    check32("pc", PC, e.pc);
                    check32("instr", INSTRUCTION, e.instr);
                    pop_cnt++;
                end
            end
            prev_br = (BRANCH_TAKEN === 1'b1) && (RESET_N === 1'b1);
        end
    end

    task automatic topup();
        exp_t e;
        if (!model_fault) begin
            while (exp_q.size() < 4) begin
                e.pc    = next_pc;
                e.instr = next_pc ^ 32'hA5A5_0000;
                exp_q.push_back(e);
                next_pc = next_pc + 32'd4;
            end
        end
    endtask

    task automatic apply_pending();
        if (pend_br) begin
            exp_q.delete();
`ifdef IF_MISALIGN_TRAP_EN
            if (pend_tgt[1:0] != 2'b00) begin
                model_fault = 1'b1;
            end else begin
                model_fault = 1'b0;
                next_pc     = pend_tgt;
            end
`else
            next_pc = {pend_tgt[31:2], 2'b00};
`endif
            pend_br = 1'b0;
        end
    endtask

    task automatic cyc(input logic st, input logic br, input logic [31:0] tgt);
        @(negedge CLK);
        apply_pending();
        STALL         = st;
        BRANCH_TAKEN  = br;
        BRANCH_TARGET = tgt;
        pend_br       = br && RESET_N;
        pend_tgt      = tgt;
        topup();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 32'd0);
    endtask

    task automatic redirect_now(input logic [31:0] tgt);
        BRANCH_TAKEN  = 1'b1;
        BRANCH_TARGET = tgt;
        pend_br       = 1'b1;
        pend_tgt      = tgt;
    endtask

    task automatic do_reset();
        RESET_N       = 1'b0;
        STALL         = 1'b0;
        BRANCH_TAKEN  = 1'b0;
        BRANCH_TARGET = 32'd0;
        pend_br       = 1'b0;
        model_fault   = 1'b0;
        exp_q.delete();
        next_pc       = 32'd0;
        @(negedge CLK);
        @(negedge CLK); #2;
        check32("rst_read", 32'(IMEM_READ), 32'd0);
        check32("rst_addr", IMEM_ADDR, 32'd0);
        check32("rst_valid", 32'(VALID), 32'd0);
        check32("rst_instr", INSTRUCTION, 32'h0000_0013);
        check32("rst_pc", PC, 32'd0);
        @(negedge CLK);
        RESET_N   = 1'b1;
        wait_left = 0;
        cyc(1'b0, 1'b0, 32'd0); #2;
        check32("first_cycle_valid", 32'(VALID), 32'd0);
        check32("first_cycle_read", 32'(IMEM_READ), 32'd1);
        check32("first_cycle_addr", IMEM_ADDR, 32'd0);
        cyc(1'b0, 1'b0, 32'd0); #2;
        check32("first_valid", 32'(VALID), 32'd1);
        check32("first_pc", PC, 32'd0);
        check32("first_instr", INSTRUCTION, 32'hA5A5_0000);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL timeout: simulation did not finish, required finish");
        $fatal(1);
    end

    initial begin : stimulus
        int  p0;
        bit  found;
        exp_t h;
        RESET_N       = 1'b0;
        STALL         = 1'b0;
        BRANCH_TAKEN  = 1'b0;
        BRANCH_TARGET = 32'd0;

        // Zero-wait streaming: one instruction per cycle.
        wait_min = 0; wait_max = 0;
        do_reset();
        run(6); #4;
        p0 = pop_cnt;
        run(10); #4;
        check32("rate_zero_wait", 32'(pop_cnt - p0), 32'd10);

        // Three busy cycles per access: one instruction every four cycles.
        wait_min = 3; wait_max = 3;
        run(8); #4;
        p0 = pop_cnt;
        run(20); #4;
        check32("rate_wait3", 32'(pop_cnt - p0), 32'd5);

        // Stall with zero-wait memory: queue fills, reads stop, head frozen.
        wait_min = 0; wait_max = 0;
        run(10);
        for (int i = 1; i <= 4; i++) begin
            cyc(1'b1, 1'b0, 32'd0); #2;
            h = exp_q[0];
            check32("stall_valid", 32'(VALID), 32'd1);
            check32("stall_pc", PC, h.pc);
            check32("stall_instr", INSTRUCTION, h.instr);
            if (i >= 2) check32("stall_read_off", 32'(IMEM_READ), 32'd0);
        end
        run(10);

        // Redirect while the read of 0x8 is held by busywait.
        wait_min = 3; wait_max = 3;
        do_reset();
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            cyc(1'b0, 1'b0, 32'd0); #2;
            if (IMEM_READ === 1'b1 && IMEM_BUSYWAIT && IMEM_ADDR == 32'h8) begin
                found = 1'b1;
                redirect_now(32'h100);
            end
        end
        check32("drain_setup", 32'(found), 32'd1);
        #3;
        p0 = pop_cnt;
        run(30); #4;
        check32("drain_progress", 32'(pop_cnt - p0 >= 3), 32'd1);

        // Back-to-back redirects; the second coincides with completion and STALL.
        wait_min = 0; wait_max = 0;
        run(10);
        cyc(1'b0, 1'b1, 32'h300);
        cyc(1'b1, 1'b1, 32'h400); #2;
        check32("coincide_read", 32'(IMEM_READ), 32'd1);
        check32("coincide_busy", 32'(IMEM_BUSYWAIT), 32'd0);
        check32("coincide_addr", IMEM_ADDR, 32'h300);
        run(12);

        // PC wraps modulo 2^32.
        cyc(1'b0, 1'b1, 32'hFFFF_FFF8);
        run(12);

        // Misaligned target.
`ifdef IF_MISALIGN_TRAP_EN
        cyc(1'b0, 1'b1, 32'h102);
        run(6); #2;
        check32("mis_flag", 32'(FETCH_MISALIGNED), 32'd1);
        check32("mis_read", 32'(IMEM_READ), 32'd0);
        check32("mis_valid", 32'(VALID), 32'd0);
        cyc(1'b0, 1'b1, 32'h200);
        #4;
        p0 = pop_cnt;
        run(10); #2;
        check32("mis_cleared", 32'(FETCH_MISALIGNED), 32'd0);
        #2;
        check32("mis_resume", 32'(pop_cnt - p0 >= 5), 32'd1);
`else
        cyc(1'b0, 1'b1, 32'h102);
        #4;
        p0 = pop_cnt;
        run(10); #4;
        check32("mis_ignored_progress", 32'(pop_cnt - p0 >= 5), 32'd1);
`endif

        // Randomised stalls, waits and aligned redirects.
        wait_min = 0; wait_max = 2;
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 9) < 3), ($urandom_range(0, 15) == 0),
                ($urandom & 32'h0000_0FFC));
        end
        run(10);

        // Reset in the middle of a busy read.
        wait_min = 3; wait_max = 3;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            cyc(1'b0, 1'b0, 32'd0); #2;
            if (IMEM_READ === 1'b1 && IMEM_BUSYWAIT) found = 1'b1;
        end
        check32("midreq_setup", 32'(found), 32'd1);
        wait_min = 0; wait_max = 0;
        do_reset();
        run(10); #4;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
